// File: rtl/nes_flash_rd_ctrl.sv
// nes_flash_rd_ctrl: parallel NOR flash read controller behind the mapper set.
// Runs the flash power-up reset sequence after system reset. It then serves
// single-byte reads with a timed CE/OE cycle and returns each byte with a
// one-cycle ack.
// Optional build macro NES_FL_HIT_CACHE_EN adds a one-entry hit cache. A
// repeated address is then answered without touching the flash.
module nes_flash_rd_ctrl #(
  parameter int unsigned ACC_CYC = 5,   // CE/OE low cycles before DQ is sampled
  parameter int unsigned RST_CYC = 25,  // flash reset pulse width in cycles
  parameter int unsigned RST_REC = 10   // recovery cycles after reset rises
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req,
  input  logic [22:0] i_addr,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_ack,
  output logic [7:0]  o_rdata,
  output logic        o_init_done,
  output logic [22:0] o_fl_addr,
  output logic        o_fl_ce_n,
  output logic        o_fl_oe_n,
  output logic        o_fl_we_n,
  output logic        o_fl_rst_n,
  input  logic [7:0]  i_fl_dq
);

  // Counter reloads are one less than the cycle count: the transition
  // fires on the edge where the counter is already zero.
  localparam logic [7:0] AccLoad = 8'(ACC_CYC - 1);
  localparam logic [7:0] RstLoad = 8'(RST_CYC - 1);
  localparam logic [7:0] RecLoad = 8'(RST_REC - 1);

  typedef enum logic [2:0] {
    StInitRst,
    StInitRec,
    StIdle,
    StAcc,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        init_done_q, init_done_d;
  logic [22:0] fl_addr_q, fl_addr_d;
  logic        fl_en_n_q, fl_en_n_d;   // drives both CE# and OE#
  logic        fl_rst_n_q, fl_rst_n_d;

  logic        cache_hit;
  logic [7:0]  cache_data;
  logic        fill;

  // A flash read completes on the edge that leaves StAcc.
  assign fill = (state_q == StAcc) && (cnt_q == 8'd0);

`ifdef NES_FL_HIT_CACHE_EN
  logic        hit_valid_q;
  logic [22:0] hit_addr_q;
  logic [7:0]  hit_data_q;

  // Hit cache: refilled by every flash read; a flush wins over a fill.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hit_valid_q <= 1'b0;
      hit_addr_q  <= '0;
      hit_data_q  <= '0;
    end else begin
      if (fill) begin
        hit_addr_q <= fl_addr_q;
        hit_data_q <= i_fl_dq;
      end
      if (i_flush) begin
        hit_valid_q <= 1'b0;
      end else if (fill) begin
        hit_valid_q <= 1'b1;
      end
    end
  end

  // A flush in the same cycle as a request forces a miss.
  assign cache_hit  = hit_valid_q && (i_addr == hit_addr_q) && !i_flush;
  assign cache_data = hit_data_q;
`else
  logic unused_flush;

  assign unused_flush = i_flush;
  assign cache_hit    = 1'b0;
  assign cache_data   = 8'h00;
`endif

  // State and registered outputs; reset puts the flash back into reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= StInitRst;
      cnt_q       <= RstLoad;
      busy_q      <= 1'b1;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      init_done_q <= 1'b0;
      fl_addr_q   <= '0;
      fl_en_n_q   <= 1'b1;
      fl_rst_n_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      init_done_q <= init_done_d;
      fl_addr_q   <= fl_addr_d;
      fl_en_n_q   <= fl_en_n_d;
      fl_rst_n_q  <= fl_rst_n_d;
    end
  end

  // Next-state and next-output decode for the init/read sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    ack_d       = ack_q;
    rdata_d     = rdata_q;
    init_done_d = init_done_q;
    fl_addr_d   = fl_addr_q;
    fl_en_n_d   = fl_en_n_q;
    fl_rst_n_d  = fl_rst_n_q;

    unique case (state_q)
      StInitRst: begin
        if (cnt_q == 8'd0) begin
          fl_rst_n_d = 1'b1;
          cnt_d      = RecLoad;
          state_d    = StInitRec;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StInitRec: begin
        if (cnt_q == 8'd0) begin
          init_done_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StIdle: begin
        if (i_req) begin
          busy_d = 1'b1;
          if (cache_hit) begin
            ack_d   = 1'b1;
            rdata_d = cache_data;
            state_d = StDone;
          end else begin
            fl_addr_d = i_addr;
            fl_en_n_d = 1'b0;
            cnt_d     = AccLoad;
            state_d   = StAcc;
          end
        end
      end
      StAcc: begin
        if (cnt_q == 8'd0) begin
          rdata_d   = i_fl_dq;
          ack_d     = 1'b1;
          fl_en_n_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StDone: begin
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StInitRst;
      end
    endcase
  end

  assign o_busy      = busy_q;
  assign o_ack       = ack_q;
  assign o_rdata     = rdata_q;
  assign o_init_done = init_done_q;
  assign o_fl_addr   = fl_addr_q;
  assign o_fl_ce_n   = fl_en_n_q;
  assign o_fl_oe_n   = fl_en_n_q;
  assign o_fl_we_n   = 1'b1;
  assign o_fl_rst_n  = fl_rst_n_q;

endmodule

// File: tb/tb_nes_flash_rd_ctrl.sv
// Directed testbench for nes_flash_rd_ctrl with a simple flash DQ model.
// Define NES_FL_HIT_CACHE_EN for both files to exercise the hit cache.
module tb_nes_flash_rd_ctrl;

`ifdef NES_FL_HIT_CACHE_EN
  localparam int HitLat = 1;
`else
  localparam int HitLat = 6;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic [22:0] addr;
  logic        flush;
  logic        busy;
  logic        ack;
  logic [7:0]  rdata;
  logic        init_done;
  logic [22:0] fl_addr;
  logic        fl_ce_n;
  logic        fl_oe_n;
  logic        fl_we_n;
  logic        fl_rst_n;
  logic [7:0]  fl_dq;

  int checks = 0;
  int errors = 0;
  int hi_run = 0;
  int last_gap = 0;

  always #5 clk = ~clk;

  nes_flash_rd_ctrl dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_req       (req),
    .i_addr      (addr),
    .i_flush     (flush),
    .o_busy      (busy),
    .o_ack       (ack),
    .o_rdata     (rdata),
    .o_init_done (init_done),
    .o_fl_addr   (fl_addr),
    .o_fl_ce_n   (fl_ce_n),
    .o_fl_oe_n   (fl_oe_n),
    .o_fl_we_n   (fl_we_n),
    .o_fl_rst_n  (fl_rst_n),
    .i_fl_dq     (fl_dq)
  );

  function automatic logic [7:0] flash_byte(input logic [22:0] a);
    case (a)
      23'h012345: return 8'hA5;
      23'h7FFFFF: return 8'h5A;
      23'h000100: return 8'h3C;
      default:    return a[7:0] ^ 8'h77;
    endcase
  endfunction

  // Flash only drives valid data while both CE# and OE# are low.
  assign fl_dq = (!fl_ce_n && !fl_oe_n) ? flash_byte(fl_addr) : 8'hFF;

  // Length of the most recent CE-high run that ended in a new access.
  always @(negedge clk) begin
    if (fl_ce_n) begin
      hi_run = hi_run + 1;
    end else begin
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release reset and time the flash reset pulse and recovery, with a
  // request held high throughout that must be ignored.
  task automatic run_init();
    int n;
    bit ce_act;
    bit ack_act;
    bit busy_low;
    ce_act   = 1'b0;
    ack_act  = 1'b0;
    busy_low = 1'b0;
    rstn = 1'b1;
    req  = 1'b1;
    addr = 23'h000042;
    n = 0;
    while (fl_rst_n == 1'b0 && n < 200) begin
      tick();
      n++;
      if (!fl_ce_n || !fl_oe_n) ce_act = 1'b1;
      if (ack) ack_act = 1'b1;
    end
    check("rst_low_cycles", n, 25);
    n = 0;
    while (init_done == 1'b0 && n < 200) begin
      tick();
      n++;
      if (!fl_ce_n || !fl_oe_n) ce_act = 1'b1;
      if (ack) ack_act = 1'b1;
      if (!init_done && !busy) busy_low = 1'b1;
    end
    req = 1'b0;
    check("rec_cycles", n, 10);
    check("init_busy_low", busy, 0);
    check("init_rst_n_high", fl_rst_n, 1);
    check("init_no_ce", ce_act, 0);
    check("init_no_ack", ack_act, 0);
    check("init_busy_held", busy_low, 0);
  endtask

  // Issue one request in the current cycle N and follow it to the ack.
  task automatic do_read(input logic [22:0] a, input logic [7:0] exp_data,
                         input int exp_lat, input logic fl);
    int cyc;
    int ack_cyc;
    int ce_cnt;
    int oe_cnt;
    cyc     = 1;
    ack_cyc = 0;
    ce_cnt  = 0;
    oe_cnt  = 0;
    req   = 1'b1;
    addr  = a;
    flush = fl;
    tick();
    req   = 1'b0;
    flush = 1'b0;
    while (cyc < 40 && ack_cyc == 0) begin
      if (ack) begin
        ack_cyc = cyc;
      end else begin
        if (!fl_ce_n) ce_cnt++;
        if (!fl_oe_n) oe_cnt++;
        if (!busy) ce_cnt = 100;
        tick();
        cyc++;
      end
    end
    check("ack_latency", ack_cyc, exp_lat);
    check("ce_low_cycles", ce_cnt, exp_lat - 1);
    check("oe_low_cycles", oe_cnt, exp_lat - 1);
    check("rdata", rdata, exp_data);
    check("ack_ce_high", fl_ce_n, 1);
    check("ack_busy", busy, 1);
    tick();
    check("ack_pulse", ack, 0);
    check("busy_release", busy, 0);
    check("addr_hold", fl_addr, a);
    check("rdata_hold", rdata, exp_data);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn  = 1'b0;
    req   = 1'b0;
    addr  = '0;
    flush = 1'b0;
    tick();
    tick();
    tick();
    check("rst_fl_rst_n", fl_rst_n, 0);
    check("rst_ce_n", fl_ce_n, 1);
    check("rst_oe_n", fl_oe_n, 1);
    check("rst_we_n", fl_we_n, 1);
    check("rst_fl_addr", fl_addr, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 1);
    check("rst_init_done", init_done, 0);

    run_init();

    do_read(23'h012345, 8'hA5, 6, 1'b0);
    // Request at the first busy=0 cycle: CE stays high for DONE plus this cycle.
    check("gap_ce_high", fl_ce_n, 1);
    do_read(23'h7FFFFF, 8'h5A, 6, 1'b0);
    check("ce_gap_cycles", last_gap, 2);
    tick();
    tick();
    check("addr_idle_hold", fl_addr, 23'h7FFFFF);
    check("we_n_const", fl_we_n, 1);

    // Hit cache: repeat hits, then a separate flush and a same-cycle flush miss.
    do_read(23'h000100, 8'h3C, 6, 1'b0);
    do_read(23'h000100, 8'h3C, HitLat, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    do_read(23'h000100, 8'h3C, 6, 1'b0);
    do_read(23'h000100, 8'h3C, HitLat, 1'b0);
    do_read(23'h000100, 8'h3C, 6, 1'b1);
    do_read(23'h000200, 8'h77, 6, 1'b0);

    // Reset in cycle N+3 of an access.
    req  = 1'b1;
    addr = 23'h055555;
    tick();
    req = 1'b0;
    tick();
    tick();
    check("mid_ce_low", fl_ce_n, 0);
    rstn = 1'b0;
    #1;
    check("mid_rst_ce_n", fl_ce_n, 1);
    check("mid_rst_oe_n", fl_oe_n, 1);
    check("mid_rst_fl_rst_n", fl_rst_n, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_init_done", init_done, 0);
    check("mid_rst_fl_addr", fl_addr, 0);
    check("mid_rst_ack", ack, 0);
    tick();
    tick();
    run_init();
    do_read(23'h000100, 8'h3C, 6, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
